// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: saturating 6-bit membrane, programmable threshold, leak and refractory.
// Optional LIF_SPIKE_COUNT_EN adds an 8-bit saturating output-spike counter (spike_cnt).
module lif_neuron_core #(
  parameter int LEAK_PERIOD = 16,
  parameter int THRES_INIT  = 32,
  parameter int V_RESET     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] wspikeI,
  input  logic       svalidI,
  input  logic [3:0] stateI,
  input  logic       reccI,
  input  logic [5:0] thresI,
  input  logic       thres_validI,
  output logic [5:0] vO,
  output logic       spikeO
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [7:0] spike_cnt
`endif
);

  typedef enum logic [1:0] {INTEG, FIRE, REFRAC} state_t;

  state_t            state;
  logic [7:0]        leak_cnt;
  logic [1:0]        refr_cnt;
  logic [5:0]        thr;
  logic              leak_tick;
  logic signed [7:0] sum;
  logic [5:0]        v_next;
  logic              fire;

  always_comb begin
    leak_tick = (leak_cnt == 8'(LEAK_PERIOD - 1));
    sum = $signed({2'b00, vO})
        + $signed({5'b0, (svalidI ? wspikeI : 3'd0)})
        - $signed({6'b0, (leak_tick ? stateI[1:0] : 2'd0)});
    // Clamp to the 6-bit membrane range; the leak can push below zero.
    if (sum < 8'sd0)
      v_next = 6'd0;
    else if (sum > 8'sd63)
      v_next = 6'd63;
    else
      v_next = sum[5:0];
    fire = (thr != 6'd0) && (v_next >= thr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INTEG;
      vO       <= 6'd0;
      spikeO   <= 1'b0;
      thr      <= 6'(THRES_INIT);
      leak_cnt <= 8'd0;
      refr_cnt <= 2'd0;
    end else begin
      leak_cnt <= leak_tick ? 8'd0 : leak_cnt + 8'd1;
      // A load is seen by the compare only from the next cycle on.
      if (thres_validI) thr <= thresI;
      case (state)
        INTEG: begin
          if (fire) begin
            spikeO <= 1'b1;
            state  <= FIRE;
            vO     <= reccI ? (v_next - thr) : 6'(V_RESET);
          end else begin
            spikeO <= 1'b0;
            vO     <= v_next;
          end
        end
        FIRE: begin
          spikeO <= 1'b0;
          if (stateI[3:2] == 2'd0) begin
            state <= INTEG;
          end else begin
            refr_cnt <= stateI[3:2] - 2'd1;
            state    <= REFRAC;
          end
        end
        REFRAC: begin
          spikeO <= 1'b0;
          if (refr_cnt != 2'd0)
            refr_cnt <= refr_cnt - 2'd1;
          else
            state <= INTEG;
        end
        default: begin
          spikeO <= 1'b0;
          state  <= INTEG;
        end
      endcase
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || (thres_validI && thresI == 6'd0))
      spike_cnt <= 8'd0;
    else if (spikeO && spike_cnt != 8'd255)
      spike_cnt <= spike_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core: an event-level neuron model checked every cycle, plus literal expectations.
module tb_lif_neuron_core;
  localparam int LP = 4;
  localparam int THR0 = 32;
  localparam int VRST = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] wspikeI = '0;
  logic       svalidI = 1'b0;
  logic [3:0] stateI = '0;
  logic       reccI = 1'b0;
  logic [5:0] thresI = '0;
  logic       thres_validI = 1'b0;
  logic [5:0] vO;
  logic       spikeO;

  int checks = 0;
  int failures = 0;

  lif_neuron_core #(.LEAK_PERIOD(LP), .THRES_INIT(THR0), .V_RESET(VRST)) dut (
    .clk(clk), .rst(rst), .wspikeI(wspikeI), .svalidI(svalidI), .stateI(stateI),
    .reccI(reccI), .thresI(thresI), .thres_validI(thres_validI), .vO(vO), .spikeO(spikeO)
  );

  always #5 clk = ~clk;

  // Model: membrane as an integer, k = edges since reset, plus "cycles still blocked" after a spike.
  int  m_v, m_thr, m_k, m_block;
  bit  m_sp, m_fire_pend, m_ok = 1'b0;

  always @(posedge clk) begin
    int s, old_thr;
    bit tick;
    if (rst) begin
      m_v = 0; m_sp = 0; m_thr = THR0; m_k = 0; m_block = 0; m_fire_pend = 0; m_ok = 1;
    end else if (m_ok) begin
      tick = (m_k % LP) == LP - 1;
      m_k++;
      old_thr = m_thr;
      if (thres_validI) m_thr = thresI;
      m_sp = 0;
      if (m_fire_pend) begin
        m_fire_pend = 0;
        m_block = stateI[3:2];
      end else if (m_block > 0) begin
        m_block--;
      end else begin
        s = m_v + (svalidI ? int'(wspikeI) : 0) - (tick ? int'(stateI[1:0]) : 0);
        if (s < 0) s = 0;
        if (s > 63) s = 63;
        if (old_thr != 0 && s >= old_thr) begin
          m_sp = 1;
          m_v = reccI ? s - old_thr : VRST;
          m_fire_pend = 1;
        end else begin
          m_v = s;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      checks++;
      if (int'(vO) != m_v || spikeO != m_sp) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual v=%0d spk=%0d expected v=%0d spk=%0d",
                 $time, vO, spikeO, m_v, m_sp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit sv, input int w, input bit tv, input int tval);
    @(negedge clk);
    svalidI = sv; wspikeI = 3'(w); thres_validI = tv; thresI = 6'(tval);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      svalidI = 1'($urandom); wspikeI = 3'($urandom); stateI = 4'($urandom);
      reccI = 1'($urandom); thresI = 6'($urandom); thres_validI = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; svalidI = 0; wspikeI = 0; stateI = 0; reccI = 0; thresI = 0; thres_validI = 0;
  endtask

  initial begin
    // Reset with random inputs, then first spike.
    do_reset(3);
    chk("rst_v", vO, 0);
    chk("rst_spk", spikeO, 0);
    cyc(1, 7, 0, 0);
    chk("first_spike_v", vO, 7);

    // Fire to V_RESET, fifth spike lost in FIRE.
    do_reset(1);
    cyc(0, 0, 1, 10);
    cyc(1, 3, 0, 0); chk("fr_v1", vO, 3);
    cyc(1, 3, 0, 0); chk("fr_v2", vO, 6);
    cyc(1, 3, 0, 0); chk("fr_v3", vO, 9); chk("fr_nospk", spikeO, 0);
    cyc(1, 3, 0, 0); chk("fr_spk", spikeO, 1); chk("fr_vpost", vO, 0);
    cyc(1, 3, 0, 0); chk("fr_ignored_v", vO, 0); chk("fr_spk_off", spikeO, 0);

    // Reset-by-subtraction with 2 refractory cycles.
    do_reset(1);
    reccI = 1; stateI = 4'b1000;
    cyc(0, 0, 1, 10);
    cyc(1, 7, 0, 0);
    cyc(1, 1, 0, 0); chk("sub_v8", vO, 8);
    cyc(1, 5, 0, 0); chk("sub_spk", spikeO, 1); chk("sub_v", vO, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 7, 0, 0); chk("sub_hold", vO, 3);
    end
    cyc(1, 2, 0, 0); chk("sub_resume", vO, 5);

    // Leak with floor; tick coinciding with a spike.
    do_reset(1);
    reccI = 0; stateI = 4'b0011;
    cyc(1, 5, 0, 0); chk("lk_v5", vO, 5);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); chk("lk_pre", vO, 5);
    cyc(0, 0, 0, 0); chk("lk_tick1", vO, 2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("lk_pre2", vO, 2);
    cyc(0, 0, 0, 0); chk("lk_floor", vO, 0);
    cyc(1, 5, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 3, 0, 0); chk("lk_coincide", vO, 5);

    // Threshold 0 disables firing; saturation; re-enable.
    do_reset(1);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 7, 0, 0); chk("sat_nospk", spikeO, 0);
    end
    chk("sat_v", vO, 63);
    cyc(0, 0, 1, 20); chk("ld_oldthr_spk", spikeO, 0); chk("ld_oldthr_v", vO, 63);
    cyc(0, 0, 0, 0); chk("ld_fire_spk", spikeO, 1); chk("ld_fire_v", vO, 0);

    // Threshold load in the same cycle as a crossing uses the old value.
    do_reset(1);
    cyc(0, 0, 1, 10);
    cyc(1, 7, 0, 0); cyc(1, 1, 0, 0); chk("tl_v8", vO, 8);
    cyc(1, 3, 1, 40); chk("tl_spk_old", spikeO, 1); chk("tl_v", vO, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 7, 0, 0); chk("tl_below40", spikeO, 0);
    end
    chk("tl_v35", vO, 35);
    cyc(1, 7, 0, 0); chk("tl_spk_new", spikeO, 1);

    // Mixed random traffic, checked by the model alone.
    do_reset(1);
    cyc(0, 0, 1, 12);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      stateI = 4'($urandom); reccI = 1'($urandom);
      svalidI = 1'($urandom); wspikeI = 3'($urandom);
      thres_validI = ($urandom_range(0, 15) == 0);
      thresI = 6'($urandom_range(0, 40));
      rst = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    rst = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lif_neuron_core.md
Name: lif_neuron_core

Overview:
- Leaky integrate-and-fire neuron core that sits inside the pad ring.
- Consumes the pad-side signals wspikeI, svalidI, stateI, reccI, thresI and thres_validI.
- Produces the membrane value vO and the output spike spikeO, which the pad ring drives off-chip.
- Single clock domain; all outputs are registered.

Parameters:
- LEAK_PERIOD, 16, cycles between leak events; range 1..255.
- THRES_INIT, 32, threshold value loaded at reset.
- V_RESET, 0, membrane value after a fire when reccI=0.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- wspikeI  input  3  synaptic weight of the incoming spike, unsigned 0..7.
- svalidI  input  1  incoming spike valid; a single-cycle qualifier for wspikeI.
- stateI  input  4  config: [1:0] leak amount per leak event, [3:2] refractory length in cycles (0..3).
- reccI  input  1  1 = reset-by-subtraction (the residual above threshold is kept); 0 = reset to V_RESET.
- thresI  input  6  new threshold value.
- thres_validI  input  1  load strobe for thresI.
- vO  output  6  membrane potential register.
- spikeO  output  1  output spike, one-cycle pulse.

Behaviour:
- Reset (rst=1 at a clk edge):
  - vO=0, spikeO=0, thr=THRES_INIT, state=INTEG.
  - Leak counter=0, refractory counter=0.
  - rst overrides all other inputs, including mid-refractory and mid-fire.
- Threshold register:
  - thr<=thresI on any cycle with thres_validI=1, in every state.
  - The compare in that same cycle uses the old thr; the new value takes effect next cycle.
- Leak counter:
  - Free-running 0..LEAK_PERIOD-1, wraps to 0, runs in all states.
  - leak_tick=1 in the cycle where the counter equals LEAK_PERIOD-1.
- Arithmetic, evaluated in INTEG only, at 8-bit internal width:
  - sum = vO + (svalidI ? wspikeI : 0) - (leak_tick ? stateI[1:0] : 0).
  - If sum<0, v_next=0; if sum>63, v_next=63; otherwise v_next=sum.
- State machine (INTEG, FIRE, REFRAC):
  - INTEG, thr!=0 and v_next>=thr:
    - spikeO<=1, state<=FIRE.
    - vO <= (reccI ? v_next-thr : V_RESET).
  - INTEG, otherwise: vO<=v_next, spikeO<=0.
  - thr=0 disables firing; vO integrates and saturates normally.
  - FIRE lasts exactly 1 cycle:
    - spikeO<=0; inputs svalidI/wspikeI are ignored and vO is held.
    - If stateI[3:2]==0, state<=INTEG; else refractory counter<=stateI[3:2]-1 and state<=REFRAC.
  - REFRAC:
    - Spikes are ignored, leak is not applied, vO is held, spikeO=0.
    - While counter!=0, decrement it; when counter==0, state<=INTEG.
    - stateI[3:2] is sampled only on the FIRE cycle; later changes have no effect on the current period.
- Latency:
  - An input spike on edge n is visible on vO after edge n.
  - A crossing produces spikeO=1 in the cycle after the crossing edge, together with the post-fire vO.
- Spike throughput: minimum spike spacing is 2 cycles plus the refractory length (FIRE plus REFRAC).
- Simultaneous svalidI and leak_tick: both are applied in the same sum.
- Input sampling: all inputs are sampled at the clk edge; there is no internal synchroniser (the pad ring supplies synchronous inputs).

Optional Feature:
- Macro: LIF_SPIKE_COUNT_EN.
- When defined:
  - Adds output port spike_cnt, output, 8 bits.
  - spike_cnt increments on every cycle spikeO=1 and saturates at 255.
  - Cleared by rst or by thres_validI=1 with thresI=0.
- When undefined: the port and counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: apply rst with inputs random -> vO=0, spikeO=0, and a first spike of w=7 with thr=32 gives vO=7 one cycle after rst deasserts.
- Fire to V_RESET: thr=10, reccI=0, stateI=0, five consecutive spikes w=3 -> vO 3,6,9, then the crossing at 12 gives spikeO=1 with vO=0; FIRE ignores the 5th spike, so vO=0 next cycle.
- Reset-by-subtraction and refractory: thr=10, reccI=1, stateI[3:2]=2, vO=8, spike w=5 -> spikeO=1 with vO=3; 1 FIRE cycle plus 2 REFRAC cycles ignore spikes; the next spike w=2 gives vO=5.
- Leak and floor: LEAK_PERIOD=4, stateI[1:0]=3, vO=5, no spikes -> vO=2 after the first tick, then 0 after the next tick (floored, no wrap); a leak tick coinciding with w=3 leaves vO unchanged.
- Saturation and threshold disable: load thr=0, then repeated w=7 spikes -> vO saturates at 63 and spikeO never asserts; loading thr=20 while vO=63 fires at the first INTEG evaluation after the load cycle.
- Threshold load timing: thr=10, vO=8, spike w=3 in the same cycle as thres_validI with thresI=40 -> fire with the old threshold (spikeO=1); thr=40 afterwards.
